id_scoreboard: RTL
==================

ID_SCOREBOARD -- requirements
Module: id_scoreboard

Interface
REQ-001 Parameters SHALL be: NREG, default 32, number of GPRs; AW, default 5, register address width; LATW, default 3, width of latency and countdown fields; MD_LAT, default 4, HI/LO result latency of mult/div in cycles.
REQ-002 Reset SHALL be rst, synchronous, active-high; clock SHALL be clk.
REQ-003 Ports SHALL be, in order:
- clk in 1: clock
- rst in 1: sync reset
- issue_valid in 1: ID holds a valid instruction
- src1_valid in 1: instruction reads src1
- src1_addr in AW: src1 register
- src2_valid in 1: instruction reads src2
- src2_addr in AW: src2 register
- dst_we in 1: instruction writes GPR
- dst_addr in AW: destination register
- dst_lat in LATW: cycles until result is forwardable (0=ALU, 1=load, ...)
- hilo_rd in 1: instruction reads HI/LO (mfhi/mflo)
- hilo_md in 1: instruction is mult/multu/div/divu
- hilo_mt in 1: instruction is mthi/mtlo
- stall_ext in 1: downstream stall, pipeline frozen
- flush in 1: all in-flight instructions squashed
- stallreq out 1: ID must hold its instruction
- issue_fire out 1: instruction leaves ID this cycle
- pend_vec out NREG: bit i set when GPR i has a nonzero countdown
- hilo_busy out 1: HI/LO countdown nonzero

Function
REQ-004 Block SHALL hold one LATW-bit countdown cnt[i] per GPR and one LATW-bit countdown hcnt for HI/LO.
REQ-005 cnt[0] SHALL be constant 0; writes to register 0 SHALL be ignored.
REQ-006 raw_haz SHALL be (src1_valid & cnt[src1_addr]!=0) | (src2_valid & cnt[src2_addr]!=0), evaluated on current-cycle state.
REQ-007 hl_haz SHALL be (hilo_rd | hilo_md | hilo_mt) & hcnt!=0.
REQ-008 stallreq SHALL be issue_valid & (raw_haz | hl_haz), combinational; it SHALL NOT depend on stall_ext or flush.
REQ-009 issue_fire SHALL be issue_valid & ~stallreq & ~stall_ext & ~flush.
REQ-010 Per cycle with flush=0 and stall_ext=0: every nonzero counter SHALL decrement by 1.
REQ-011 When stall_ext=1 and flush=0, all counters SHALL hold; no issue occurs.
REQ-012 On issue_fire with dst_we=1 and dst_addr!=0, cnt[dst_addr] next SHALL be max(dst_lat, cnt[dst_addr] decremented per REQ-010), for WAW safety.
REQ-013 On issue_fire with hilo_md=1, hcnt next SHALL be MD_LAT (saturated to 2^LATW-1); with hilo_mt=1, hcnt next SHALL be 1.
REQ-014 An instruction whose src equals its own dst SHALL check the pre-update counter (no self-stall).
REQ-015 flush=1 SHALL clear all cnt[] and hcnt next cycle, overriding issue and stall_ext.
REQ-016 pend_vec and hilo_busy SHALL be derived combinationally from the registered counters.
REQ-017 Forwarding paths SHALL cover every result with countdown 0; the block SHALL NOT assert stallreq for such sources.

Reset
REQ-018 On rst=1 all cnt[] and hcnt SHALL be 0 next edge; pend_vec=0, hilo_busy=0, stallreq=0 while issue_valid=0.
REQ-019 rst SHALL override flush, stall_ext and issue_fire; rst mid-countdown SHALL discard all pending state.

Verification
REQ-020 Load-use: issue lw dst=8 dst_lat=1; next cycle addu src1=8 -> stallreq=1 one cycle, issue_fire=1 the cycle after; pend_vec[8] high exactly one cycle.
REQ-021 ALU back-to-back: addu dst=9 dst_lat=0; next addu src2=9 -> stallreq=0, issue_fire=1, pend_vec=0.
REQ-022 Mult then mflo, MD_LAT=4: mult fires at T; mflo stalled T+1..T+4 (hilo_busy=1), fires T+5; second mult at T+1 also stalls until T+5.
REQ-023 Stall freeze: lw dst=3 lat=2, stall_ext=1 for 3 cycles after issue -> pend_vec[3] held 3 cycles, then clears 2 cycles after stall_ext drops.
REQ-024 Flush/reset mid-operation: div in flight (hcnt=3), cnt[5]=2; flush=1 one cycle -> next cycle pend_vec=0, hilo_busy=0, mfhi fires; same via rst=1.
REQ-025 WAW/zero: lw dst=7 lat=3 then addu dst=7 lat=0 -> cnt[7] stays 2, not overwritten to 0; any write to dst 0 leaves pend_vec[0]=0.

Source files
------------

// File: rtl/id_scoreboard.sv
// id_scoreboard: per-register result countdowns for the ID stage.
// Each GPR has a countdown of cycles until its pending result can be
// forwarded; a source with a nonzero countdown stalls issue. HI/LO has one
// shared countdown covering mult/div and mthi/mtlo writers.
module id_scoreboard #(
   parameter int NREG   = 32,
   parameter int AW     = 5,
   parameter int LATW   = 3,
   parameter int MD_LAT = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            issue_valid,
   input  logic            src1_valid,
   input  logic [AW-1:0]   src1_addr,
   input  logic            src2_valid,
   input  logic [AW-1:0]   src2_addr,
   input  logic            dst_we,
   input  logic [AW-1:0]   dst_addr,
   input  logic [LATW-1:0] dst_lat,
   input  logic            hilo_rd,
   input  logic            hilo_md,
   input  logic            hilo_mt,
   input  logic            stall_ext,
   input  logic            flush,
   output logic            stallreq,
   output logic            issue_fire,
   output logic [NREG-1:0] pend_vec,
   output logic            hilo_busy
);

   // MD_LAT may not fit the counter width; clamp it to the largest count.
   localparam int CMAX   = (1 << LATW) - 1;
   localparam int MD_SAT = (MD_LAT > CMAX) ? CMAX : MD_LAT;
   localparam logic [LATW-1:0] MD_INIT = LATW'(MD_SAT);

   logic [LATW-1:0] cnt_q [NREG];
   logic [LATW-1:0] cnt_d [NREG];
   logic [LATW-1:0] hcnt_q, hcnt_d;

   logic [LATW-1:0] s1_cnt, s2_cnt;
   logic            raw_haz, hl_haz, dst_hit;

   // Look up the pre-update countdowns of both sources (addresses beyond
   // the register file read as idle).
   always_comb begin
      s1_cnt = '0;
      s2_cnt = '0;
      if (int'(src1_addr) < NREG) s1_cnt = cnt_q[src1_addr];
      if (int'(src2_addr) < NREG) s2_cnt = cnt_q[src2_addr];
   end

   // A countdown of zero means the value is on a forwarding path already.
   assign raw_haz    = (src1_valid & (s1_cnt != '0)) | (src2_valid & (s2_cnt != '0));
   assign hl_haz     = (hilo_rd | hilo_md | hilo_mt) & (hcnt_q != '0);
   assign stallreq   = issue_valid & (raw_haz | hl_haz);
   assign issue_fire = issue_valid & ~stallreq & ~stall_ext & ~flush;
   assign dst_hit    = issue_fire & dst_we & (dst_addr != '0);

   // GPR countdown next state: decrement, then take the longer of the old
   // and new result latency on a write (WAW), freeze on stall, clear on flush.
   always_comb begin
      logic [LATW-1:0] dec;
      dec = '0;
      for (int i = 0; i < NREG; i++) begin
         dec      = (cnt_q[i] == '0) ? '0 : cnt_q[i] - 1'b1;
         cnt_d[i] = dec;
         if (dst_hit && (dst_addr == AW'(i)) && (dst_lat > dec)) cnt_d[i] = dst_lat;
         if (stall_ext) cnt_d[i] = cnt_q[i];
         if (flush)     cnt_d[i] = '0;
         if (i == 0)    cnt_d[i] = '0;
      end
   end

   // HI/LO countdown next state: mult/div reloads the full latency, mthi/mtlo
   // only needs one cycle before the value is forwardable.
   always_comb begin
      hcnt_d = (hcnt_q == '0) ? '0 : hcnt_q - 1'b1;
      if (issue_fire && hilo_md)      hcnt_d = MD_INIT;
      else if (issue_fire && hilo_mt) hcnt_d = LATW'(1);
      if (stall_ext) hcnt_d = hcnt_q;
      if (flush)     hcnt_d = '0;
   end

   // Counter registers; reset discards every pending result.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
         hcnt_q <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
         hcnt_q <= hcnt_d;
      end
   end

   // Busy flags straight from the registered counters.
   always_comb begin
      for (int i = 0; i < NREG; i++) pend_vec[i] = (cnt_q[i] != '0);
      hilo_busy = (hcnt_q != '0);
   end

endmodule
